// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus bundle: ROM read port, pipeline control inputs and
// the IF/ID register outputs seen by decode.
// Optional macro: FETCH_PERF_CNT_EN adds the fetch_count/stall_count signals.
interface instr_fetch_if;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    // Fetch stage side: drives the ROM address and the IF/ID outputs.
    modport master (
        output rom_addr, id_instr, id_pc, id_pc4, id_valid, halted,
               fetch_count, stall_count,
        input  rom_data, stall, redirect, redirect_pc
    );

    // Environment side: ROM plus the pipeline control logic.
    modport slave (
        input  rom_addr, id_instr, id_pc, id_pc4, id_valid, halted,
               fetch_count, stall_count,
        output rom_data, stall, redirect, redirect_pc
    );
`else
    // Fetch stage side: drives the ROM address and the IF/ID outputs.
    modport master (
        output rom_addr, id_instr, id_pc, id_pc4, id_valid, halted,
        input  rom_data, stall, redirect, redirect_pc
    );

    // Environment side: ROM plus the pipeline control logic.
    modport slave (
        input  rom_addr, id_instr, id_pc, id_pc4, id_valid, halted,
        output rom_data, stall, redirect, redirect_pc
    );
`endif
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: program counter, ROM word addressing and the IF/ID
// pipeline register, with stall, redirect and halt-word stop.
// Optional macro: FETCH_PERF_CNT_EN enables saturating fetch/stall counters.
module instr_fetch #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input logic          clk,
    input logic          rst,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {START, RUN, HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;

    // The ROM is word addressed and only 4 KB deep, so the upper pc bits wrap.
    assign bus.rom_addr = pc[11:2];
    assign bus.id_instr = id_instr;
    assign bus.id_pc    = id_pc;
    assign bus.id_pc4   = id_pc4;
    assign bus.id_valid = id_valid;
    assign bus.halted   = (state == HALT);

    // Main sequencer: redirect beats stall, stall beats fetch, halt word parks fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= START;
            pc       <= PC_RESET;
            id_instr <= 32'h0;
            id_pc    <= 32'h0;
            id_pc4   <= 32'h0;
            id_valid <= 1'b0;
        end else begin
            case (state)
                START: begin
                    if (bus.redirect) begin
                        pc       <= bus.redirect_pc & 32'hFFFF_FFFC;
                        id_instr <= 32'h0;
                        id_valid <= 1'b0;
                    end
                    state <= RUN;
                end
                RUN: begin
                    if (bus.redirect) begin
                        pc       <= bus.redirect_pc & 32'hFFFF_FFFC;
                        id_instr <= 32'h0;
                        id_valid <= 1'b0;
                    end else if (!bus.stall) begin
                        id_instr <= bus.rom_data;
                        id_pc    <= pc;
                        id_pc4   <= pc + 32'd4;
                        id_valid <= 1'b1;
                        if (bus.rom_data == HALT_WORD) begin
                            state <= HALT;
                        end else begin
                            pc <= pc + 32'd4;
                        end
                    end
                end
                HALT: begin
                    if (bus.redirect) begin
                        pc       <= bus.redirect_pc & 32'hFFFF_FFFC;
                        id_instr <= 32'h0;
                        id_valid <= 1'b0;
                        state    <= RUN;
                    end else if (!bus.stall) begin
                        id_valid <= 1'b0;
                    end
                end
                default: state <= START;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    assign bus.fetch_count = fetch_count;
    assign bus.stall_count = stall_count;

    // Saturating counters of fetch edges (halt word included) and stalled edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (state == RUN && !bus.redirect && !bus.stall &&
                fetch_count != 32'hFFFF_FFFF) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (state != START && bus.stall && !bus.redirect &&
                stall_count != 32'hFFFF_FFFF) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized stall/redirect
// traffic checked every cycle against a behavioural fetch model.
// Honours FETCH_PERF_CNT_EN when the counters are built in.
module tb_instr_fetch;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] PC0  = 32'h0000_0000;
    localparam logic [31:0] PC1  = 32'h0000_0FFC;

    logic clk;
    logic rst;
    logic [31:0] rom [1024];

    int checks;
    int errors;

    instr_fetch_if bus0 ();
    instr_fetch_if bus1 ();

    assign bus0.rom_data = rom[bus0.rom_addr];
    assign bus1.rom_data = rom[bus1.rom_addr];

    instr_fetch #(.PC_RESET(PC0), .HALT_WORD(HALT)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    instr_fetch #(.PC_RESET(PC1), .HALT_WORD(HALT)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural view of dut0: where fetch is, what decode holds, and whether it has stopped.
    logic [31:0] m_pc;
    logic        m_started;
    logic        m_halted;
    logic [31:0] m_instr;
    logic [31:0] m_idpc;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_fc;
    logic [31:0] m_sc;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_pc      = PC0;
        m_started = 1'b0;
        m_halted  = 1'b0;
        m_instr   = 32'h0;
        m_idpc    = 32'h0;
        m_pc4     = 32'h0;
        m_valid   = 1'b0;
        m_fc      = 32'h0;
        m_sc      = 32'h0;
    endtask

    task automatic modelStep(input logic s, input logic r, input logic [31:0] rp);
        logic [31:0] w;
        if (!m_started) begin
            m_started = 1'b1;
            if (r) m_pc = {rp[31:2], 2'b00};
        end else if (r) begin
            m_pc     = {rp[31:2], 2'b00};
            m_valid  = 1'b0;
            m_instr  = 32'h0;
            m_halted = 1'b0;
        end else if (s) begin
            if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else begin
            w       = rom[m_pc[11:2]];
            m_instr = w;
            m_idpc  = m_pc;
            m_pc4   = m_pc + 4;
            m_valid = 1'b1;
            if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
            if (w == HALT) m_halted = 1'b1;
            else           m_pc = m_pc + 4;
        end
    endtask

    task automatic compareModel();
        checkOutput("rom_addr", 32'(bus0.rom_addr), 32'(m_pc[11:2]));
        checkOutput("id_instr", bus0.id_instr, m_instr);
        checkOutput("id_valid", 32'(bus0.id_valid), 32'(m_valid));
        checkOutput("halted", 32'(bus0.halted), 32'(m_halted));
        if (m_valid) begin
            checkOutput("id_pc", bus0.id_pc, m_idpc);
            checkOutput("id_pc4", bus0.id_pc4, m_pc4);
        end
`ifdef FETCH_PERF_CNT_EN
        checkOutput("fetch_count", bus0.fetch_count, m_fc);
        checkOutput("stall_count", bus0.stall_count, m_sc);
`endif
    endtask

    // Drives one cycle of control from the falling edge, then checks after the rising edge.
    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rp);
        bus0.stall       = s;
        bus0.redirect    = r;
        bus0.redirect_pc = rp;
        modelStep(s, r, rp);
        @(posedge clk);
        @(negedge clk);
        compareModel();
    endtask

    task automatic pulseReset();
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_id_valid", 32'(bus0.id_valid), 32'h0);
        checkOutput("rst_id_instr", bus0.id_instr, 32'h0);
        checkOutput("rst_id_pc", bus0.id_pc, 32'h0);
        checkOutput("rst_halted", 32'(bus0.halted), 32'h0);
        checkOutput("rst_rom_addr", 32'(bus0.rom_addr), 32'(PC0[11:2]));
        #1 rst = 1'b0;
        modelReset();
    endtask

    function automatic logic [31:0] randWord();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h0;
        return w;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus0.stall = 1'b0; bus0.redirect = 1'b0; bus0.redirect_pc = 32'h0;
        bus1.stall = 1'b0; bus1.redirect = 1'b0; bus1.redirect_pc = 32'h0;
        for (int i = 0; i < 1024; i++) rom[i] = randWord();
        rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
        modelReset();

        repeat (2) @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset released");
        checkOutput("reset_id_valid", 32'(bus0.id_valid), 32'h0);
        checkOutput("reset_id_instr", bus0.id_instr, 32'h0);
        checkOutput("reset_id_pc", bus0.id_pc, 32'h0);
        checkOutput("reset_id_pc4", bus0.id_pc4, 32'h0);
        checkOutput("reset_halted", 32'(bus0.halted), 32'h0);
        checkOutput("reset_rom_addr1", 32'(bus1.rom_addr), 32'h3FF);
        compareModel();

        // Straight-line fetch from PC_RESET, plus the 4 KB wrap on the second instance.
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("edge1_valid", 32'(bus0.id_valid), 32'h0);
        checkOutput("edge1_valid1", 32'(bus1.id_valid), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("edge2_instr", bus0.id_instr, 32'h11);
        checkOutput("edge2_pc", bus0.id_pc, 32'h0);
        checkOutput("edge2_valid", 32'(bus0.id_valid), 32'h1);
        checkOutput("wrap_first_instr", bus1.id_instr, rom[1023]);
        checkOutput("wrap_first_pc", bus1.id_pc, 32'hFFC);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("edge3_instr", bus0.id_instr, 32'h22);
        checkOutput("edge3_pc4", bus0.id_pc4, 32'h8);
        checkOutput("wrap_next_pc", bus1.id_pc, 32'h1000);
        checkOutput("wrap_next_instr", bus1.id_instr, 32'h11);

        // Three stalled edges hold decode and the ROM address.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            checkOutput("stall_instr", bus0.id_instr, 32'h22);
            checkOutput("stall_rom_addr", 32'(bus0.rom_addr), 32'h2);
            checkOutput("stall_valid", 32'(bus0.id_valid), 32'h1);
        end
`ifdef FETCH_PERF_CNT_EN
        checkOutput("stall_count3", bus0.stall_count, 32'h3);
`endif
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("after_stall_instr", bus0.id_instr, 32'h33);

        // Redirect wins over stall and drops the low address bits.
        applyStimulus(1'b1, 1'b1, 32'h0000_0103);
        checkOutput("redir_bubble", 32'(bus0.id_valid), 32'h0);
        checkOutput("redir_rom_addr", 32'(bus0.rom_addr), 32'h40);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("redir_target_instr", bus0.id_instr, rom[32'h40]);
        checkOutput("redir_target_pc", bus0.id_pc, 32'h100);

        // Halt word at word 2 stops fetch until a redirect restarts it.
        pulseReset();
        rom[2] = HALT;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("halt_word_pc", bus0.id_pc, 32'h8);
        checkOutput("halt_word_valid", 32'(bus0.id_valid), 32'h1);
        checkOutput("halt_word_instr", bus0.id_instr, HALT);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("halted_flag", 32'(bus0.halted), 32'h1);
            checkOutput("halted_valid", 32'(bus0.id_valid), 32'h0);
            checkOutput("halted_rom_addr", 32'(bus0.rom_addr), 32'h2);
        end
`ifdef FETCH_PERF_CNT_EN
        checkOutput("halt_fetch_count", bus0.fetch_count, 32'h3);
`endif
        applyStimulus(1'b0, 1'b1, 32'h0);
        checkOutput("restart_halted", 32'(bus0.halted), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("restart_instr", bus0.id_instr, 32'h11);
        checkOutput("restart_pc", bus0.id_pc, 32'h0);

        // Randomized traffic over a fresh ROM with occasional halt words.
        for (int i = 0; i < 1024; i++) begin
            if ($urandom_range(0, 15) == 0) rom[i] = HALT;
            else                            rom[i] = randWord();
        end
        for (int n = 0; n < 600; n++) begin
            logic s, r;
            logic [31:0] rp;
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 9) == 0);
            rp = $urandom;
            if (n == 300) pulseReset();
            applyStimulus(s, r, rp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage for the single-issue lab CPU. It holds the program counter, drives the word address of the 1024×32 asynchronous instruction ROM, and registers the returned word into the IF/ID pipeline register for decode. It also handles stall, branch/jump redirect and a halt-instruction stop. The ROM read path is purely combinational; all state lives in this block.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000, byte address loaded into PC on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- rom_addr  out  10  ROM word address = pc[11:2] (combinational).
- rom_data  in  32  ROM read data for rom_addr, valid in the same cycle.
- stall  in  1  hold PC and IF/ID register.
- redirect  in  1  load PC from redirect_pc and flush IF/ID.
- redirect_pc  in  32  redirect byte address; bits [1:0] ignored (forced 0).
- id_instr  out  32  registered instruction to decode.
- id_pc  out  32  byte address of id_instr.
- id_pc4  out  32  id_pc + 4.
- id_valid  out  1  id_* holds a real instruction.
- halted  out  1  fetch stopped on HALT_WORD.
- fetch_count  out  32  present only with FETCH_PERF_CNT_EN.
- stall_count  out  32  present only with FETCH_PERF_CNT_EN.

## Operation
- Reset values: pc=PC_RESET, id_instr=0, id_pc=0, id_pc4=0, id_valid=0, halted=0, counters=0, state=START.
- States: START, RUN, HALT. halted=1 exactly in HALT.
- START: one cycle, no fetch. At the next edge the state goes to RUN, and id_valid stays 0. A redirect in START is honoured (PC loaded, go to RUN).
- RUN, per edge, priority redirect > stall > fetch:
  - redirect: pc <= {redirect_pc[31:2],2'b00}; id_valid <= 0; id_instr <= 0. Applies even with stall=1.
  - stall: pc, id_* unchanged.
  - fetch: id_instr <= rom_data; id_pc <= pc; id_pc4 <= pc+4; id_valid <= 1.
    - If rom_data == HALT_WORD, pc holds and the state goes to HALT; the halt word itself is delivered with id_valid=1.
    - Otherwise pc <= pc+4.
- HALT:
  - redirect: the same load as in RUN, then go to RUN with halted=0 next cycle.
  - stall: hold.
  - otherwise: id_valid <= 0, and pc/id_instr/id_pc/id_pc4 hold. No further ROM words are latched.
- Arithmetic: pc is 32-bit and wraps modulo 2^32. rom_addr truncates, so fetch wraps at 4 KB (pc=0xFFC then 0x1000 reads word 0).
- Reset asserted mid-operation: all registers return to reset values immediately, regardless of clk.

## Timing
- rom_addr changes only after a pc update edge. It follows pc combinationally.
- Fetch latency: the word at pc appears on id_instr one edge after it is presented.
- After reset release:
  - edge 1: START→RUN.
  - edge 2: rom[PC_RESET>>2] is latched, id_valid=1.
- Redirect penalty: one bubble (id_valid=0) at the redirect edge. The target word is latched at the following edge, absent stall.
- stall and redirect are sampled only at rising edges. No combinational path from stall or redirect to any output.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - fetch_count increments on every fetch edge, including the halt word.
  - stall_count increments on every RUN/HALT edge with stall=1 && redirect=0.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- FETCH_PERF_CNT_EN undefined: both ports and their registers are absent. All other behaviour is identical.

## Test plan
- ROM words 0..3 = 0x11,0x22,0x33,0x44, PC_RESET=0, no stall: id_instr/id_pc sequence 0x11/0x0, 0x22/0x4, 0x33/0x8 from edge 2. id_valid=1 from edge 2. id_pc4=id_pc+4.
- stall high for 3 edges while id_instr=0x22: id_*, rom_addr=2 and id_valid held for 3 edges. Then 0x33 is latched. stall_count=3 when the macro is defined.
- Redirect and stall together, redirect_pc=0x0000_0103: next edge gives id_valid=0 and rom_addr=0x40. The following edge latches rom[0x40] with id_pc=0x100.
- Word 2 = HALT_WORD: halt word delivered with id_pc=0x8, id_valid=1. Then halted=1 and id_valid=0 indefinitely. rom_addr stays 2 and fetch_count=3. A redirect to 0x0 restarts at word 0 with halted=0.
- PC_RESET=0xFFC: the first fetch is rom[1023]. The next fetch has id_pc=0x1000 and data rom[0].
- rst asserted between edges mid-run: outputs go to reset values before the next edge. After release, START is followed by a fetch from PC_RESET.
